// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard sequencer: tracks in-flight destination registers, stalls on RAW,
// freezes on memory back-pressure and flushes wrong-path work when a branch resolves in WB.
module pipeline_hazard_ctrl #(
  parameter int STAGES     = 3,
  parameter int FLUSH_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1_addr,
  input  logic        dec_rs1_use,
  input  logic [4:0]  dec_rs2_addr,
  input  logic        dec_rs2_use,
  input  logic [4:0]  dec_rd_addr,
  input  logic        dec_rf_wen,
  input  logic        mem_stall,
  input  logic        wb_branch_taken,
  output logic        stall_flg,
  output logic        wb_branch_hazard,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  logic        ent_valid_r [STAGES];
  logic [4:0]  ent_rd_r    [STAGES];
  logic [1:0]  flush_cnt_r;
  logic [15:0] stall_count_r;
  logic [15:0] flush_count_r;

  logic take_br_s;
  logic raw_s;
  logic issue_s;

  assign take_br_s        = wb_branch_taken & ~mem_stall;
  assign wb_branch_hazard = take_br_s | (flush_cnt_r != 2'd0);
  assign stall_flg        = mem_stall | (dec_valid & raw_s & ~wb_branch_hazard);
  assign issue_s          = dec_valid & ~stall_flg & ~wb_branch_hazard &
                            dec_rf_wen & (dec_rd_addr != 5'd0);
  assign stall_count      = stall_count_r;
  assign flush_count      = flush_count_r;

  // RAW detect against every tracked entry; the WB entry counts since there is no bypass
  always_comb begin
    raw_s = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      raw_s = raw_s | (ent_valid_r[i] &
                       ((dec_rs1_use & (ent_rd_r[i] == dec_rs1_addr)) |
                        (dec_rs2_use & (ent_rd_r[i] == dec_rs2_addr))));
    end
  end

  // Destination tracker: hold on freeze, wipe on taken branch, otherwise shift toward WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        ent_valid_r[i] <= 1'b0;
        ent_rd_r[i]    <= 5'd0;
      end
    end else if (mem_stall) begin
      for (int i = 0; i < STAGES; i++) begin
        ent_valid_r[i] <= ent_valid_r[i];
        ent_rd_r[i]    <= ent_rd_r[i];
      end
    end else if (take_br_s) begin
      for (int i = 0; i < STAGES; i++) begin
        ent_valid_r[i] <= 1'b0;
        ent_rd_r[i]    <= 5'd0;
      end
    end else begin
      ent_valid_r[0] <= issue_s;
      ent_rd_r[0]    <= issue_s ? dec_rd_addr : 5'd0;
      for (int i = 1; i < STAGES; i++) begin
        ent_valid_r[i] <= ent_valid_r[i-1];
        ent_rd_r[i]    <= ent_rd_r[i-1];
      end
    end
  end

  // Flush hold counter; only non-frozen cycles consume the hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_r <= 2'd0;
    end else if (take_br_s) begin
      flush_cnt_r <= 2'(FLUSH_HOLD);
    end else if ((flush_cnt_r != 2'd0) && !mem_stall) begin
      flush_cnt_r <= flush_cnt_r - 2'd1;
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

  // Saturating performance counters, counting through freezes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= 16'd0;
      flush_count_r <= 16'd0;
    end else begin
      if (stall_flg && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (wb_branch_hazard && (flush_count_r != 16'hFFFF)) begin
        flush_count_r <= flush_count_r + 16'd1;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed corner sequences,
// and randomized traffic against an in-flight-instruction reference model.
module tb_pipeline_hazard_ctrl;
  localparam int STAGES     = 3;
  localparam int FLUSH_HOLD = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic [4:0]  dec_rs1_addr;
  logic        dec_rs1_use;
  logic [4:0]  dec_rs2_addr;
  logic        dec_rs2_use;
  logic [4:0]  dec_rd_addr;
  logic        dec_rf_wen;
  logic        mem_stall;
  logic        wb_branch_taken;
  logic        stall_flg;
  logic        wb_branch_hazard;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  pipeline_hazard_ctrl #(.STAGES(STAGES), .FLUSH_HOLD(FLUSH_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs1_use(dec_rs1_use),
    .dec_rs2_addr(dec_rs2_addr), .dec_rs2_use(dec_rs2_use),
    .dec_rd_addr(dec_rd_addr), .dec_rf_wen(dec_rf_wen),
    .mem_stall(mem_stall), .wb_branch_taken(wb_branch_taken),
    .stall_flg(stall_flg), .wb_branch_hazard(wb_branch_hazard),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [4:0] r1;
    bit       u1;
    bit [4:0] r2;
    bit       u2;
    bit [4:0] rd;
    bit       wen;
    bit       ms;
    bit       br;
    bit       exp_stall;
    bit       exp_haz;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model: destination of each instruction in flight (0 = nothing that writes)
  int m_dest[$];
  int m_hold;
  int m_sc;
  int m_fc;

  int act_stall, act_haz, act_sc, act_fc;
  int base0, base1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_dest = {};
    for (int i = 0; i < STAGES; i++) m_dest.push_back(0);
    m_hold = 0;
    m_sc   = 0;
    m_fc   = 0;
  endfunction

  task automatic step(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                      input bit u2, input bit [4:0] rd, input bit wen, input bit ms,
                      input bit br, input bit chk);
    bit flush_now, hazard, dep, stall;
    @(negedge clk);
    dec_valid = v; dec_rs1_addr = r1; dec_rs1_use = u1; dec_rs2_addr = r2;
    dec_rs2_use = u2; dec_rd_addr = rd; dec_rf_wen = wen; mem_stall = ms;
    wb_branch_taken = br;
    #1;
    flush_now = br && !ms;
    hazard = flush_now || (m_hold > 0);
    dep = 1'b0;
    foreach (m_dest[i])
      if (m_dest[i] != 0 && ((u1 && m_dest[i] == r1) || (u2 && m_dest[i] == r2))) dep = 1'b1;
    stall = ms || (v && dep && !hazard);
    act_stall = stall_flg; act_haz = wb_branch_hazard;
    act_sc = stall_count;  act_fc = flush_count;
    if (chk) begin
      check("stall_flg", act_stall, stall);
      check("wb_branch_hazard", act_haz, hazard);
      check("stall_count", act_sc, m_sc);
      check("flush_count", act_fc, m_fc);
    end
    if (stall && m_sc < 65535) m_sc++;
    if (hazard && m_fc < 65535) m_fc++;
    if (flush_now) begin
      foreach (m_dest[i]) m_dest[i] = 0;
      m_hold = FLUSH_HOLD;
    end else if (!ms) begin
      void'(m_dest.pop_back());
      m_dest.push_front((v && !stall && !hazard && wen) ? int'(rd) : 0);
      if (m_hold > 0) m_hold--;
    end
  endtask

  task automatic idle(input bit chk);
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, chk);
  endtask

  task automatic expect_out(input string name, input int s, input int h);
    check({name, ".stall"}, act_stall, s);
    check({name, ".hazard"}, act_haz, h);
  endtask

  // asynchronous reset applied mid-cycle; outputs must react without a clock edge
  task automatic reset_pulse();
    rst_n = 1'b0;
    mem_stall = 1'b1;
    wb_branch_taken = 1'b0;
    #1;
    check("rst.stall_eq_mem_stall", stall_flg, 1);
    check("rst.hazard", wb_branch_hazard, 0);
    check("rst.stall_count", stall_count, 0);
    check("rst.flush_count", flush_count, 0);
    dec_valid = 1'b0; dec_rs1_use = 1'b0; dec_rs2_use = 1'b0; dec_rf_wen = 1'b0;
    mem_stall = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, 1, 0};
    tbl[2]  = '{1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, 1, 0};
    tbl[3]  = '{1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, 1, 0};
    tbl[4]  = '{1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 5'd0, 0, 5'd8, 1, 5'd0, 0, 0, 0, 1, 0};
    tbl[10] = '{1, 5'd0, 0, 5'd8, 1, 5'd0, 0, 0, 0, 1, 0};
    tbl[11] = '{1, 5'd0, 0, 5'd8, 1, 5'd0, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1, 0};
    tbl[13] = '{0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0};

    rst_n = 1'b0;
    dec_valid = 1'b0; dec_rs1_addr = 5'd0; dec_rs1_use = 1'b0; dec_rs2_addr = 5'd0;
    dec_rs2_use = 1'b0; dec_rd_addr = 5'd0; dec_rf_wen = 1'b0; mem_stall = 1'b0;
    wb_branch_taken = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    idle(1'b1);
    expect_out("reset_state", 0, 0);
    check("reset_state.stall_count", act_sc, 0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].r1, tbl[i].u1, tbl[i].r2, tbl[i].u2, tbl[i].rd, tbl[i].wen,
           tbl[i].ms, tbl[i].br, 1'b1);
      expect_out($sformatf("tbl[%0d]", i), tbl[i].exp_stall, tbl[i].exp_haz);
      if (i == 5) check("tbl.raw_stall_count", act_sc, 3);
    end
    idle(1'b1);
    check("tbl.total_stall_count", act_sc, 6);

    // flush with two valid younger entries and a pending RAW stall
    step(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1); base0 = act_fc;
    step(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 1);
    step(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 0, 0, 1);
    step(1, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 1, 1); expect_out("br.take", 0, 1);
    step(1, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 0, 1); expect_out("br.hold", 0, 1);
    step(1, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 0, 1); expect_out("br.after", 0, 0);
    idle(1'b1);
    check("br.flush_count_delta", act_fc - base0, 2);

    // branch held during a freeze is only taken once the freeze drops
    for (int i = 0; i < 3; i++) begin
      step(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 1); expect_out("held.frozen", 1, 0);
    end
    step(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1); expect_out("held.take", 0, 1);
    step(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1); expect_out("held.hold", 0, 1);
    idle(1'b1); expect_out("held.done", 0, 0);

    // freeze with producer x5 sitting in MEM, then the remaining RAW stall cycles
    step(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 1); base0 = act_sc;
    step(1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 0, 0, 1); expect_out("frz.raw1", 1, 0);
    step(1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 1, 0, 1); expect_out("frz.ms", 1, 0); base1 = act_sc;
    for (int i = 0; i < 3; i++) begin
      step(1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 1, 0, 1); expect_out("frz.ms", 1, 0);
    end
    step(1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 0, 0, 1); expect_out("frz.resume1", 1, 0);
    check("frz.stall_count_4", act_sc - base1, 4);
    step(1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 0, 0, 1); expect_out("frz.resume2", 1, 0);
    step(1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 0, 0, 1); expect_out("frz.issue", 0, 0);
    check("frz.stall_count_total", act_sc - base0, 7);

    // asynchronous reset in the flush hold cycle
    step(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1); expect_out("rstflush.take", 0, 1);
    @(negedge clk);
    wb_branch_taken = 1'b0;
    #1;
    check("rstflush.hold_before_reset", wb_branch_hazard, 1);
    reset_pulse();
    idle(1'b1); expect_out("rstflush.after", 0, 0);

    // reset with a producer in flight leaves the tracker empty
    step(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 1);
    @(negedge clk);
    reset_pulse();
    step(1, 5'd5, 1, 5'd5, 1, 5'd3, 1, 0, 0, 1); expect_out("rst.tracker_empty", 0, 0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), 1'($urandom),
           5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 8), 1'b1);
    end

    // stall counter saturation
    @(negedge clk);
    reset_pulse();
    for (int n = 0; n < 65540; n++) step(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1'b0);
    idle(1'b1);
    check("sat.stall_count", act_sc, 16'hFFFF);
    idle(1'b1);
    check("sat.stall_count_holds", act_sc, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
